ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width.
REQ-002 SHALL have parameter AW, 5, register-address width.
REQ-003 SHALL have parameter MUL_CYCLES, 4, multiply latency in cycles (>=2).
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port validE  in  1  E-stage instruction valid.
REQ-007 SHALL have port flushE  in  1  kill E-stage instruction.
REQ-008 SHALL have port stallM  in  1  M stage cannot accept.
REQ-009 SHALL have port ALUopE  in  4  ALU operation; OP_MUL = 4'b1111.
REQ-010 SHALL have port SrcASelE  in  2  srcA: 00 PCE, 10 r1E, x1 zero.
REQ-011 SHALL have port SrcBSelE  in  1  srcB: 0 r2E, 1 immE.
REQ-012 SHALL have port brCondE  in  3  branch condition (NONE/EQ/NE/LT/GE/LTU/GEU).
REQ-013 SHALL have port ctrlE  in  8  passthrough {strCtrl[2:0],RegWrite,MemWrite,MemtoReg,PCBranch,spare}.
REQ-014 SHALL have ports immE, PCE, r1E, r2E  in  XLEN  operands.
REQ-015 SHALL have port rdE  in  AW  destination register.
REQ-016 SHALL have port busyE  out  1  E cannot accept a new instruction this cycle.
REQ-017 SHALL have ports validM, takenM  out  1  M valid; branch taken.
REQ-018 SHALL have ports ctrlM  out 8, rdM  out AW, ALUoutM/PCplusImmM/r2M  out XLEN.

Function
REQ-019 SHALL compute PCplusImm = (PCE + immE) mod 2^XLEN, immE full XLEN width.
REQ-020 SHALL compute taken = validE and brCond true on r1E vs r2E (signed for LT/GE, unsigned for LTU/GEU); NONE gives 0.
REQ-021 SHALL, for non-MUL ops, update all M registers on a rising edge when stallM=0 (latency 1).
REQ-022 SHALL hold every M register unchanged while stallM=1.
REQ-023 SHALL load validM=0 (bubble) when flushE=1 and stallM=0; other M fields don't-care but takenM=0, ctrlM RegWrite/MemWrite=0.
REQ-024 SHALL implement FSM IDLE/MUL: IDLE->MUL on validE & ALUopE=OP_MUL & !flushE & !stallM, counter loaded MUL_CYCLES-1.
REQ-025 SHALL in MUL decrement counter each cycle; at counter 0 and stallM=0 write low XLEN bits of srcA*srcB into ALUoutM with validM=1, return IDLE.
REQ-026 SHALL in MUL at counter 0 with stallM=1 wait in MUL, counter at 0.
REQ-027 SHALL abort on flushE in MUL: next state IDLE, bubble into M.
REQ-028 SHALL drive busyE = stallM | (state=MUL & !(counter=0 & !stallM)) | (IDLE & MUL start).
REQ-029 SHALL capture MUL operands at IDLE->MUL; E inputs may change afterwards.

Reset
REQ-030 SHALL, on rst low, asynchronously clear validM, takenM, ctrlM, rdM, ALUoutM, PCplusImmM, r2M to 0, FSM to IDLE, counter to 0.
REQ-031 SHALL abort any MUL in progress on reset with no M write after release.

Configuration
REQ-032 SHALL, with EX_MUL_EN defined, include the FSM, counter and multiplier as above.
REQ-033 SHALL, without EX_MUL_EN, omit them: OP_MUL yields ALUoutM=0, latency 1, busyE=stallM.

Structure
REQ-034 SHALL place ALU opcodes incl. OP_MUL, brCond encodings, SrcASel encodings and ctrl bit indices in package ex_pkg.
REQ-035 SHALL reuse existing alu and add one sub-module ex_mul_seq (multiplier + counter + FSM).

Verification
REQ-036 ADD r1E=5,immE=7,SrcASel=10,SrcBSel=1 -> next cycle ALUoutM=12, validM=1.
REQ-037 PCE=0x100, immE=0xFFFFFFFC, brCond=LTU, r1E=1, r2E=2 -> PCplusImmM=0xFC, takenM=1.
REQ-038 MUL r1E=6, r2E=7, MUL_CYCLES=4 -> busyE high 4 cycles, ALUoutM=42 on 4th edge after issue.
REQ-039 stallM=1 two cycles mid-stream -> M outputs unchanged, then resume with no lost/duplicated instruction.
REQ-040 flushE during MUL cycle 2 -> validM=0, FSM IDLE, busyE low next cycle; rst low mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage (ALU opcodes, branch
//   conditions, srcA/srcB selects, ctrl bit positions, multiply FSM states).
// Latency: n/a (definitions only). Backpressure: n/a.
package ex_pkg;

  // ALU operations. Unlisted codes produce zero.
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'b1111;

  // Branch conditions. Code 7 is unused and never taken.
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LTU  = 3'd5;
  localparam logic [2:0] BR_GEU  = 3'd6;

  // srcA select: bit 0 set forces zero regardless of bit 1.
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_R1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO = 2'b01;

  // srcB select.
  localparam logic SRCB_R2  = 1'b0;
  localparam logic SRCB_IMM = 1'b1;

  // ctrl byte layout: {strCtrl[2:0], RegWrite, MemWrite, MemtoReg, PCBranch, spare}
  localparam int CTRL_SPARE    = 0;
  localparam int CTRL_PCBRANCH = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_STR_LO   = 5;
  localparam int CTRL_STR_HI   = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_e;

  // A bubble must never commit architectural state: strip the write enables.
  function automatic logic [7:0] ctrl_kill(input logic [7:0] ctrl);
    logic [7:0] c;
    c = ctrl;
    c[CTRL_REGWRITE] = 1'b0;
    c[CTRL_MEMWRITE] = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU for the execute stage.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: op (ex_pkg OP_* code), a/b operands, y result. OP_MUL and
//   unassigned codes return zero; multiply lives in ex_mul_seq.
module alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_SLL:   y = a << shamt;
      OP_SRL:   y = a >> shamt;
      OP_SRA:   y = $signed(a) >>> shamt;
      OP_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: multi-cycle multiplier with IDLE/MUL FSM and down-counter.
// Latency: MUL_CYCLES cycles from start to result commit (longer while stalled).
// Backpressure: counts down under stall, then waits at zero until stall_m drops.
// Ports: clk, rst (async active-low); valid_e/is_mul_e/flush_e/stall_m
//   control; src_a/src_b/rd_e/ctrl_e captured at start; outputs mul_start,
//   mul_in (state is MUL), mul_done (commit this cycle), mul_busy, and the
//   registered result/rd/ctrl for the M stage.
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_e,
  input  logic            is_mul_e,
  input  logic            flush_e,
  input  logic            stall_m,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [AW-1:0]   rd_e,
  input  logic [7:0]      ctrl_e,
  output logic            mul_start,
  output logic            mul_in,
  output logic            mul_done,
  output logic            mul_busy,
  output logic [XLEN-1:0] mul_res,
  output logic [AW-1:0]   mul_rd,
  output logic [7:0]      mul_ctrl
);

  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_CYCLES - 1);

  mul_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [XLEN-1:0] prod_q, prod_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [7:0]      ctrl_q, ctrl_d;
  logic            cnt_zero;

  assign cnt_zero  = (cnt_q == '0);
  assign mul_in    = (state_q == ST_MUL);
  assign mul_start = (state_q == ST_IDLE) & valid_e & is_mul_e & ~flush_e & ~stall_m;
  assign mul_done  = mul_in & cnt_zero & ~stall_m & ~flush_e;
  assign mul_busy  = (mul_in & ~(cnt_zero & ~stall_m)) | mul_start;

  assign mul_res  = prod_q;
  assign mul_rd   = rd_q;
  assign mul_ctrl = ctrl_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    // The product register is refreshed on every MUL cycle from the captured
    // operands; MUL_CYCLES >= 2 guarantees at least one refresh before the
    // counter reaches zero, so the multiplier gets a full cycle of slack.
    prod_d  = mul_in ? (op_a_q * op_b_q) : prod_q;

    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          state_d = ST_MUL;
          cnt_d   = CNT_INIT;
          op_a_d  = src_a;
          op_b_d  = src_b;
          rd_d    = rd_e;
          ctrl_d  = ctrl_e;
        end
      end
      ST_MUL: begin
        if (flush_e) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!stall_m) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      prod_q  <= prod_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage -- operand select, ALU, branch compare, PC+imm,
//   optional multi-cycle multiply, and the E->M pipeline register.
// Latency: 1 cycle for ALU ops; MUL_CYCLES+1 edges for OP_MUL when enabled.
// Backpressure: stallM freezes all M registers; busyE tells upstream to hold E.
// Build option: define EX_MUL_EN to include the sequential multiplier
//   (ex_mul_seq). Without it OP_MUL behaves as a 1-cycle op returning zero.
// Ports: clk, rst (async active-low); E-side validE/flushE/ALUopE/SrcASelE/
//   SrcBSelE/brCondE/ctrlE/immE/PCE/r1E/r2E/rdE; stallM from M; outputs
//   busyE and the M register set validM/takenM/ctrlM/rdM/ALUoutM/PCplusImmM/r2M.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validE,
  input  logic            flushE,
  input  logic            stallM,
  input  logic [3:0]      ALUopE,
  input  logic [1:0]      SrcASelE,
  input  logic            SrcBSelE,
  input  logic [2:0]      brCondE,
  input  logic [7:0]      ctrlE,
  input  logic [XLEN-1:0] immE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] r1E,
  input  logic [XLEN-1:0] r2E,
  input  logic [AW-1:0]   rdE,
  output logic            busyE,
  output logic            validM,
  output logic            takenM,
  output logic [7:0]      ctrlM,
  output logic [AW-1:0]   rdM,
  output logic [XLEN-1:0] ALUoutM,
  output logic [XLEN-1:0] PCplusImmM,
  output logic [XLEN-1:0] r2M
);

  logic [XLEN-1:0] src_a, src_b, alu_y, pc_imm;
  logic            br_true;
  logic            kill;

  logic            mul_start, mul_in, mul_done, mul_busy;
  logic [XLEN-1:0] mul_res;
  logic [AW-1:0]   mul_rd;
  logic [7:0]      mul_ctrl;

  logic            valid_m_q, valid_m_d;
  logic            taken_m_q, taken_m_d;
  logic [7:0]      ctrl_m_q, ctrl_m_d;
  logic [AW-1:0]   rd_m_q, rd_m_d;
  logic [XLEN-1:0] alu_out_m_q, alu_out_m_d;
  logic [XLEN-1:0] pc_imm_m_q, pc_imm_m_d;
  logic [XLEN-1:0] r2_m_q, r2_m_d;

  // Operand select.
  always_comb begin
    casez (SrcASelE)
      2'b?1:   src_a = '0;
      SRCA_R1: src_a = r1E;
      default: src_a = PCE;
    endcase
    src_b = (SrcBSelE == SRCB_IMM) ? immE : r2E;
  end

  alu #(.XLEN(XLEN)) u_alu (
    .op (ALUopE),
    .a  (src_a),
    .b  (src_b),
    .y  (alu_y)
  );

  assign pc_imm = PCE + immE;

  // Branch compare always uses the raw register operands.
  always_comb begin
    br_true = 1'b0;
    case (brCondE)
      BR_EQ:   br_true = (r1E == r2E);
      BR_NE:   br_true = (r1E != r2E);
      BR_LT:   br_true = ($signed(r1E) <  $signed(r2E));
      BR_GE:   br_true = ($signed(r1E) >= $signed(r2E));
      BR_LTU:  br_true = (r1E <  r2E);
      BR_GEU:  br_true = (r1E >= r2E);
      default: br_true = 1'b0;
    endcase
  end

`ifdef EX_MUL_EN
  ex_mul_seq #(
    .XLEN       (XLEN),
    .AW         (AW),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .valid_e   (validE),
    .is_mul_e  (ALUopE == OP_MUL),
    .flush_e   (flushE),
    .stall_m   (stallM),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_e      (rdE),
    .ctrl_e    (ctrlE),
    .mul_start (mul_start),
    .mul_in    (mul_in),
    .mul_done  (mul_done),
    .mul_busy  (mul_busy),
    .mul_res   (mul_res),
    .mul_rd    (mul_rd),
    .mul_ctrl  (mul_ctrl)
  );
`else
  assign mul_start = 1'b0;
  assign mul_in    = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_busy  = 1'b0;
  assign mul_res   = '0;
  assign mul_rd    = '0;
  assign mul_ctrl  = '0;
`endif

  assign busyE = stallM | mul_busy;

  // A slot becomes a bubble when it is flushed, empty, or belongs to a
  // multiply that has not finished yet (the result is written separately).
  assign kill = flushE | ~validE | mul_start | mul_in;

  always_comb begin
    valid_m_d   = valid_m_q;
    taken_m_d   = taken_m_q;
    ctrl_m_d    = ctrl_m_q;
    rd_m_d      = rd_m_q;
    alu_out_m_d = alu_out_m_q;
    pc_imm_m_d  = pc_imm_m_q;
    r2_m_d      = r2_m_q;
    if (!stallM) begin
      if (mul_done) begin
        // E inputs may have moved on; only captured fields are trustworthy.
        valid_m_d   = 1'b1;
        taken_m_d   = 1'b0;
        ctrl_m_d    = mul_ctrl;
        rd_m_d      = mul_rd;
        alu_out_m_d = mul_res;
        pc_imm_m_d  = '0;
        r2_m_d      = '0;
      end else begin
        valid_m_d   = ~kill;
        taken_m_d   = ~kill & br_true;
        ctrl_m_d    = kill ? ctrl_kill(ctrlE) : ctrlE;
        rd_m_d      = rdE;
        alu_out_m_d = alu_y;
        pc_imm_m_d  = pc_imm;
        r2_m_d      = r2E;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_m_q   <= 1'b0;
      taken_m_q   <= 1'b0;
      ctrl_m_q    <= '0;
      rd_m_q      <= '0;
      alu_out_m_q <= '0;
      pc_imm_m_q  <= '0;
      r2_m_q      <= '0;
    end else begin
      valid_m_q   <= valid_m_d;
      taken_m_q   <= taken_m_d;
      ctrl_m_q    <= ctrl_m_d;
      rd_m_q      <= rd_m_d;
      alu_out_m_q <= alu_out_m_d;
      pc_imm_m_q  <= pc_imm_m_d;
      r2_m_q      <= r2_m_d;
    end
  end

  assign validM     = valid_m_q;
  assign takenM     = taken_m_q;
  assign ctrlM      = ctrl_m_q;
  assign rdM        = rd_m_q;
  assign ALUoutM    = alu_out_m_q;
  assign PCplusImmM = pc_imm_m_q;
  assign r2M        = r2_m_q;

endmodule
